// File: rtl/bcd_ctrl_pkg.sv
// Purpose: shared op codes, FSM states and BCD digit helpers for the BCD counter sequencer.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package bcd_ctrl_pkg;

    localparam int                 DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_LOAD       = 3'd1;
    localparam logic [2:0] OP_CLEAR      = 3'd2;
    localparam logic [2:0] OP_COUNT_UP   = 3'd3;
    localparam logic [2:0] OP_COUNT_DOWN = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

    // Single source of truth for a digit's update rule; the digit register and
    // the optional terminal-count lookahead both evaluate it.
    // Priority: clear > load > inc > dec.
    function automatic logic [DIGIT_W-1:0] digit_next(
        input logic [DIGIT_W-1:0] value,
        input logic               clr,
        input logic               load,
        input logic [DIGIT_W-1:0] load_val,
        input logic               inc,
        input logic               dec
    );
        logic [DIGIT_W-1:0] r;
        r = value;
        if (clr)
            r = '0;
        else if (load)
            r = load_val;
        else if (inc)
            r = (value == BCD_MAX) ? '0 : value + 1'b1;
        else if (dec)
            r = (value == '0) ? BCD_MAX : value - 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Purpose: one decade (0..9) digit register with clear/load/inc/dec enables.
// Latency: value updates on the edge where an enable is high; carry/borrow are combinational.
// Backpressure: none; the sequencer guarantees at most the intended enable per cycle.
// Ports: clock, reset_n (async active-low); clr/load/inc/dec enables, load_val;
//        value (registered digit), carry_out (inc at 9), borrow_out (dec at 0).
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_val,
    input  logic               inc,
    input  logic               dec,
    output logic [DIGIT_W-1:0] value,
    output logic               carry_out,
    output logic               borrow_out
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            value <= '0;
        else
            value <= digit_next(value, clr, load, load_val, inc, dec);
    end

    assign carry_out  = inc && (value == BCD_MAX);
    assign borrow_out = dec && (value == '0);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Purpose: sequencer for a DIGITS-long BCD up/down counter; only writer of the digit registers.
// Latency: accept edge, then 1 EXEC cycle (NOP/LOAD/CLEAR/illegal) or 1..DIGITS (count ripple); done one cycle later.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid while busy is held off.
// Ports: clock, reset_n (async active-low); cmd_valid/cmd_ready/cmd_op/cmd_data command channel;
//        count_bcd (digit i at [4i+3:4i]), busy, done/wrap/sat/err pulses, at_zero.
// Optional: BCD_CTRL_TC_EN adds tc_bcd input and registered tc_hit output.
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [DIGIT_W*DIGITS-1:0] cmd_data,
    output logic [DIGIT_W*DIGITS-1:0] count_bcd,
    output logic                      busy,
    output logic                      done,
    output logic                      wrap,
    output logic                      sat,
    output logic                      err,
    output logic                      at_zero
`ifdef BCD_CTRL_TC_EN
    ,
    input  logic [DIGIT_W*DIGITS-1:0] tc_bcd,
    output logic                      tc_hit
`endif
);

    localparam int                 CW       = DIGIT_W * DIGITS;
    localparam int                 IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIGITS - 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [2:0]        op_q;
    logic [CW-1:0]     data_q;

    logic [DIGITS-1:0] d_clr, d_load, d_inc, d_dec;
    logic [DIGITS-1:0] d_carry, d_borrow;

    logic accept;
    logic load_ok;
    logic ripple;
    logic finish;
    logic sat_nxt, err_nxt, wrap_nxt;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == EXEC);
    assign accept    = cmd_valid && cmd_ready;
    assign at_zero   = (count_bcd == '0);

    // A LOAD is all-or-nothing: a single bad nibble rejects the whole value.
    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_ok(data_q[i*DIGIT_W +: DIGIT_W]))
                load_ok = 1'b0;
        end
    end

    // Digit enables for the current EXEC cycle. Count ops touch only the
    // digit under idx; the ripple decision comes back via carry/borrow.
    always_comb begin
        d_clr   = '0;
        d_load  = '0;
        d_inc   = '0;
        d_dec   = '0;
        sat_nxt = 1'b0;
        err_nxt = 1'b0;
        if (state == EXEC) begin
            case (op_q)
                OP_NOP: ;
                OP_LOAD: begin
                    if (load_ok)
                        d_load = '1;
                    else
                        err_nxt = 1'b1;
                end
                OP_CLEAR:      d_clr = '1;
                OP_COUNT_UP:   d_inc[idx] = 1'b1;
                OP_COUNT_DOWN: begin
                    // Saturate at zero instead of wrapping to all-9s.
                    if (at_zero)
                        sat_nxt = 1'b1;
                    else
                        d_dec[idx] = 1'b1;
                end
                default: err_nxt = 1'b1;
            endcase
        end
    end

    assign ripple   = |(d_carry | d_borrow);
    assign wrap_nxt = d_carry[DIGITS-1];

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                    idx_nxt   = '0;
                end
            end
            EXEC: begin
                if (ripple && (idx != LAST_IDX)) begin
                    idx_nxt = idx + 1'b1;
                end else begin
                    state_nxt = IDLE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx    <= '0;
            op_q   <= OP_NOP;
            data_q <= '0;
            done   <= 1'b0;
            wrap   <= 1'b0;
            sat    <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end
            done <= finish;
            wrap <= finish && wrap_nxt;
            sat  <= finish && sat_nxt;
            err  <= finish && err_nxt;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit u_digit (
            .clock      (clock),
            .reset_n    (reset_n),
            .clr        (d_clr[g]),
            .load       (d_load[g]),
            .load_val   (data_q[g*DIGIT_W +: DIGIT_W]),
            .inc        (d_inc[g]),
            .dec        (d_dec[g]),
            .value      (count_bcd[g*DIGIT_W +: DIGIT_W]),
            .carry_out  (d_carry[g]),
            .borrow_out (d_borrow[g])
        );
    end

`ifdef BCD_CTRL_TC_EN
    // Look ahead to the post-edge count so tc_hit lines up with the cycle in
    // which the matching count is visible and the sequencer is idle.
    logic [CW-1:0] count_nxt;

    always_comb begin
        count_nxt = count_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            count_nxt[i*DIGIT_W +: DIGIT_W] = digit_next(count_bcd[i*DIGIT_W +: DIGIT_W],
                                                         d_clr[i], d_load[i],
                                                         data_q[i*DIGIT_W +: DIGIT_W],
                                                         d_inc[i], d_dec[i]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            tc_hit <= 1'b0;
        else
            tc_hit <= (state_nxt == IDLE) && (count_nxt == tc_bcd);
    end
`endif

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Purpose: self-checking bench for bcd_count_ctrl against an integer-arithmetic counter model.
// Latency: checks EXEC-cycle counts, done timing and ripple intermediates.
// Backpressure: exercises cmd_valid held high while busy.
module tb_bcd_count_ctrl;

    localparam int DIGITS = 4;
    localparam int CW     = 4 * DIGITS;
    localparam int MOD    = 10000;

    localparam logic [2:0] C_NOP  = 3'd0;
    localparam logic [2:0] C_LOAD = 3'd1;
    localparam logic [2:0] C_CLR  = 3'd2;
    localparam logic [2:0] C_UP   = 3'd3;
    localparam logic [2:0] C_DOWN = 3'd4;

    logic          clock;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [CW-1:0] cmd_data;
    logic [CW-1:0] count_bcd;
    logic          busy, done, wrap, sat, err, at_zero;
`ifdef BCD_CTRL_TC_EN
    logic [CW-1:0] tc_bcd;
    logic          tc_hit;
`endif

    int checks = 0;
    int fails  = 0;
    int model_n = 0;
    logic [CW-1:0] trace_q[$];

    bcd_count_ctrl #(.DIGITS(DIGITS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .count_bcd (count_bcd),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .sat       (sat),
        .err       (err),
        .at_zero   (at_zero)
`ifdef BCD_CTRL_TC_EN
        ,
        .tc_bcd    (tc_bcd),
        .tc_hit    (tc_hit)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (decimal integer arithmetic) ----------------
    function automatic logic [CW-1:0] to_bcd(input int n);
        logic [CW-1:0] r;
        int v;
        r = '0;
        v = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit nibbles_ok(input logic [CW-1:0] b);
        for (int i = 0; i < DIGITS; i++)
            if (b[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int from_bcd(input logic [CW-1:0] b);
        int r, p;
        r = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r = r + int'(b[i*4 +: 4]) * p;
            p = p * 10;
        end
        return r;
    endfunction

    // A count op takes one cycle per decimal digit whose value changes.
    function automatic int diff_digits(input int a, input int b);
        int c, x, y;
        c = 0;
        x = a;
        y = b;
        for (int i = 0; i < DIGITS; i++) begin
            if ((x % 10) != (y % 10)) c++;
            x = x / 10;
            y = y / 10;
        end
        return (c == 0) ? 1 : c;
    endfunction

    task automatic model_step(input logic [2:0] op, input logic [CW-1:0] data, inout int n,
                              output int lat, output bit w, output bit s, output bit e);
        int old;
        old = n;
        lat = 1;
        w = 0; s = 0; e = 0;
        case (op)
            C_NOP:  ;
            C_LOAD: if (nibbles_ok(data)) n = from_bcd(data); else e = 1;
            C_CLR:  n = 0;
            C_UP: begin
                n   = (n + 1) % MOD;
                w   = (old == MOD - 1);
                lat = diff_digits(old, n);
            end
            C_DOWN: begin
                if (n == 0) s = 1;
                else begin
                    n   = n - 1;
                    lat = diff_digits(old, n);
                end
            end
            default: e = 1;
        endcase
    endtask

    // ---------------- driver: issue one command, observe its execution ----------------
    task automatic send_cmd(input logic [2:0] op, input logic [CW-1:0] data,
                            output int lat, output logic w, output logic s, output logic e,
                            output logic pulse_ok);
        int guard;
        trace_q.delete();
        lat = 0; w = 0; s = 0; e = 0; pulse_ok = 0;
        @(negedge clock);
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = CW'($urandom);
        @(negedge clock);
        guard = 0;
        while (!done && guard < 50) begin
            if (busy) begin
                lat++;
                trace_q.push_back(count_bcd);
            end
            guard++;
            @(negedge clock);
        end
        if (!done) begin
            lat = -1;
        end else begin
            w = wrap; s = sat; e = err;
            pulse_ok = cmd_ready && !busy;
            @(negedge clock);
            pulse_ok = pulse_ok && !done;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        cmd_valid = 1'b0;
        cmd_op    = C_NOP;
        cmd_data  = '0;
        reset_n   = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (count_bcd !== 16'h0000) begin fails++; $display("FAIL reset_count: got %h expected 0000", count_bcd); end
        checks++;
        if ({busy, cmd_ready, done, wrap, sat, err, at_zero} !== 7'b0100001) begin
            fails++;
            $display("FAIL reset_flags: busy/ready/done/wrap/sat/err/at_zero got %b expected 0100001",
                     {busy, cmd_ready, done, wrap, sat, err, at_zero});
        end
        reset_n = 1'b1;
        model_n = 0;
        @(negedge clock);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL reset_release: ready=%b done=%b expected 1/0", cmd_ready, done); end
    endtask

    task automatic test_ripple();
        int lat; logic w, s, e, p;
        logic [CW-1:0] exp_tr [3];
        send_cmd(C_LOAD, 16'h0199, lat, w, s, e, p);
        send_cmd(C_UP, 16'h0000, lat, w, s, e, p);
        model_n = 200;
        exp_tr[0] = 16'h0199; exp_tr[1] = 16'h0190; exp_tr[2] = 16'h0100;
        checks++;
        if (lat !== 3) begin fails++; $display("FAIL ripple_latency: got %0d expected 3", lat); end
        checks++;
        if (trace_q.size() != 3) begin fails++; $display("FAIL ripple_trace_len: got %0d expected 3", trace_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (trace_q[i] !== exp_tr[i]) begin fails++; $display("FAIL ripple_step%0d: got %h expected %h", i, trace_q[i], exp_tr[i]); end
            end
        end
        checks++;
        if (count_bcd !== 16'h0200 || w !== 1'b0 || p !== 1'b1) begin
            fails++; $display("FAIL ripple_final: count=%h wrap=%b pulse=%b expected 0200/0/1", count_bcd, w, p);
        end
    endtask

    task automatic test_wrap();
        int lat; logic w, s, e, p;
        send_cmd(C_LOAD, 16'h9999, lat, w, s, e, p);
        send_cmd(C_UP, 16'h1234, lat, w, s, e, p);
        model_n = 0;
        checks++;
        if (lat !== 4 || count_bcd !== 16'h0000) begin fails++; $display("FAIL wrap_up: lat=%0d count=%h expected 4/0000", lat, count_bcd); end
        checks++;
        if (w !== 1'b1 || s !== 1'b0 || e !== 1'b0 || p !== 1'b1) begin
            fails++; $display("FAIL wrap_flags: wrap/sat/err/pulse got %b%b%b%b expected 1001", w, s, e, p);
        end
    endtask

    task automatic test_down_sat();
        int lat; logic w, s, e, p;
        send_cmd(C_CLR, 16'hFFFF, lat, w, s, e, p);
        send_cmd(C_DOWN, 16'h0000, lat, w, s, e, p);
        checks++;
        if (lat !== 1 || count_bcd !== 16'h0000 || s !== 1'b1 || p !== 1'b1) begin
            fails++; $display("FAIL down_sat: lat=%0d count=%h sat=%b pulse=%b expected 1/0000/1/1", lat, count_bcd, s, p);
        end
        send_cmd(C_LOAD, 16'h1000, lat, w, s, e, p);
        send_cmd(C_DOWN, 16'h0000, lat, w, s, e, p);
        model_n = 999;
        checks++;
        if (lat !== 4 || count_bcd !== 16'h0999 || s !== 1'b0 || w !== 1'b0) begin
            fails++; $display("FAIL down_borrow: lat=%0d count=%h sat=%b wrap=%b expected 4/0999/0/0", lat, count_bcd, s, w);
        end
    endtask

    task automatic test_err();
        int lat; logic w, s, e, p;
        send_cmd(C_LOAD, 16'h12A4, lat, w, s, e, p);
        checks++;
        if (count_bcd !== 16'h0999 || e !== 1'b1 || lat !== 1) begin
            fails++; $display("FAIL bad_load: count=%h err=%b lat=%0d expected 0999/1/1", count_bcd, e, lat);
        end
        send_cmd(3'd6, 16'h5555, lat, w, s, e, p);
        checks++;
        if (count_bcd !== 16'h0999 || e !== 1'b1 || lat !== 1 || p !== 1'b1) begin
            fails++; $display("FAIL illegal_op: count=%h err=%b lat=%0d pulse=%b expected 0999/1/1/1", count_bcd, e, lat, p);
        end
        send_cmd(C_NOP, 16'h0000, lat, w, s, e, p);
        checks++;
        if (count_bcd !== 16'h0999 || e !== 1'b0 || lat !== 1) begin
            fails++; $display("FAIL nop: count=%h err=%b lat=%0d expected 0999/0/1", count_bcd, e, lat);
        end
    endtask

    task automatic test_reset_mid_ripple();
        int lat, dones; logic w, s, e, p;
        send_cmd(C_LOAD, 16'h0999, lat, w, s, e, p);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = C_UP; cmd_data = '0;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clock);   // two update edges have passed
        checks++;
        if (count_bcd !== 16'h0900 || busy !== 1'b1) begin fails++; $display("FAIL mid_ripple_pre: count=%h busy=%b expected 0900/1", count_bcd, busy); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (count_bcd !== 16'h0000 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL mid_ripple_reset: count=%h busy=%b ready=%b done=%b expected 0000/0/1/0", count_bcd, busy, cmd_ready, done);
        end
        dones = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || count_bcd !== 16'h0000) begin fails++; $display("FAIL mid_ripple_after: dones=%0d count=%h expected 0/0000", dones, count_bcd); end
    endtask

    task automatic test_back_to_back();
        int lat, accepts, dones, hits, hit_bad; logic w, s, e, p;
`ifdef BCD_CTRL_TC_EN
        tc_bcd = 16'h0010;
`endif
        send_cmd(C_LOAD, 16'h0008, lat, w, s, e, p);
        accepts = 0; dones = 0; hits = 0; hit_bad = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_op = C_UP; cmd_data = CW'($urandom);
        for (int c = 0; c < 30; c++) begin
            if (accepts == 3) cmd_valid = 1'b0;
            if (done) dones++;
`ifdef BCD_CTRL_TC_EN
            if (tc_hit) begin
                hits++;
                if (count_bcd !== 16'h0010) hit_bad++;
            end
`endif
            if (cmd_valid && cmd_ready) accepts++;
            @(negedge clock);
        end
        model_n = 11;
        checks++;
        if (accepts !== 3 || dones !== 3) begin fails++; $display("FAIL b2b_counts: accepts=%0d dones=%0d expected 3/3", accepts, dones); end
        checks++;
        if (count_bcd !== 16'h0011) begin fails++; $display("FAIL b2b_final: got %h expected 0011", count_bcd); end
`ifdef BCD_CTRL_TC_EN
        checks++;
        if (hits !== 1 || hit_bad !== 0) begin fails++; $display("FAIL tc_hit: hits=%0d wrong_count_hits=%0d expected 1/0", hits, hit_bad); end
`endif
    endtask

    task automatic test_random();
        int lat, exp_lat, exp_n, r, sel;
        logic w, s, e, p;
        bit ew, es, ee, trace_ok;
        logic [2:0] op;
        logic [CW-1:0] data;
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 15);
            if (r <= 5)       op = C_UP;
            else if (r <= 9)  op = C_DOWN;
            else if (r <= 11) op = C_LOAD;
            else if (r == 12) op = C_CLR;
            else if (r == 13) op = C_NOP;
            else              op = 3'($urandom_range(5, 7));
            for (int d = 0; d < DIGITS; d++) begin
                sel = $urandom_range(0, 19);
                if (sel < 7)        data[d*4 +: 4] = 4'd9;
                else if (sel < 11)  data[d*4 +: 4] = 4'd0;
                else if (sel == 19) data[d*4 +: 4] = 4'($urandom_range(10, 15));
                else                data[d*4 +: 4] = 4'($urandom_range(0, 9));
            end
            exp_n = model_n;
            model_step(op, data, exp_n, exp_lat, ew, es, ee);
            send_cmd(op, data, lat, w, s, e, p);
            checks++;
            if (count_bcd !== to_bcd(exp_n)) begin fails++; $display("FAIL rnd%0d_count op=%0d: got %h expected %h", it, op, count_bcd, to_bcd(exp_n)); end
            checks++;
            if (lat !== exp_lat) begin fails++; $display("FAIL rnd%0d_latency op=%0d: got %0d expected %0d", it, op, lat, exp_lat); end
            checks++;
            if ({w, s, e} !== {ew, es, ee}) begin fails++; $display("FAIL rnd%0d_flags op=%0d: wrap/sat/err got %b expected %b", it, op, {w, s, e}, {ew, es, ee}); end
            checks++;
            if (p !== 1'b1) begin fails++; $display("FAIL rnd%0d_done_pulse: got %b expected 1", it, p); end
            trace_ok = 1'b1;
            foreach (trace_q[i]) if (!nibbles_ok(trace_q[i])) trace_ok = 1'b0;
            checks++;
            if (trace_ok !== 1'b1) begin fails++; $display("FAIL rnd%0d_digit_range: got %b expected 1", it, trace_ok); end
            model_n = exp_n;
        end
    endtask

    initial begin
`ifdef BCD_CTRL_TC_EN
        tc_bcd = 16'hFFFF;
`endif
        test_reset();
        test_ripple();
        test_wrap();
        test_down_sat();
        test_err();
        test_reset_mid_ripple();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
